itype_decode_queue: RTL and testbench

ITYPE_DECODE_QUEUE -- requirements
Module: itype_decode_queue

---
 rtl/itype_decode_queue.sv | 169 ++++++++++++++++
 tb/tb_itype_decode_queue.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/itype_decode_queue.sv
// itype_decode_queue
// Instruction queue that classifies each instruction as it is enqueued and
// stores the result alongside it, so the consumer sees the instruction type
// and an illegal flag without any decode logic on the dequeue side.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of all queued entries
//   in_valid/in_instr/in_ready     enqueue handshake
//   out_valid/out_ready            dequeue handshake
//   out_instr/out_itype/out_illegal  head-entry payload (zero when empty)
//   count             current occupancy
//   illegal_cnt       saturating count of illegal instructions accepted
module itype_decode_queue #(
    parameter int DEPTH  = 4,
    parameter bit EXT_EN = 1'b0,
    parameter int CNT_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    input  logic [31:0]               in_instr,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_instr,
    output logic [2:0]                out_itype,
    output logic                      out_illegal,
    output logic [$clog2(DEPTH):0]    count,
    output logic [CNT_W-1:0]          illegal_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 36;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Returns {itype, illegal} for one instruction.
    function automatic logic [3:0] decode_itype(input logic [31:0] instr);
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] res;
        op = instr[31:26];
        fn = instr[5:0];
        case (op)
            6'b000000: res = (fn != 6'b000000) ? {3'b010, 1'b0} : {3'b011, 1'b0};
            6'b000101: res = {3'b101, 1'b0};
            6'b000010: res = {3'b110, 1'b0};
            6'b101011,
            6'b100011: res = {3'b100, 1'b0};
            6'b000100: res = EXT_EN ? {3'b101, 1'b0} : {3'b000, 1'b1};
            6'b000011: res = EXT_EN ? {3'b110, 1'b0} : {3'b000, 1'b1};
            default:   res = {3'b000, 1'b1};
        endcase
        return res;
    endfunction

    logic [EW-1:0]    mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    cnt_r;
    logic [EW-1:0]    head_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [CNT_W-1:0] ill_cnt_r;

    logic [EW-1:0]    new_entry_s;
    logic             push_s;
    logic             pop_s;
    logic [PW-1:0]    wr_nxt_s;
    logic [PW-1:0]    rd_nxt_s;
    logic [CW-1:0]    cnt_nxt_s;
    logic [EW-1:0]    head_nxt_s;

    assign new_entry_s = {in_instr, decode_itype(in_instr)};
    assign push_s      = in_valid & in_ready_r;
    assign pop_s       = out_valid_r & out_ready;

    // Next pointers and occupancy; flush overrides any same-cycle push/pop.
    always_comb begin
        wr_nxt_s  = wr_ptr_r;
        rd_nxt_s  = rd_ptr_r;
        cnt_nxt_s = cnt_r;
        if (flush) begin
            wr_nxt_s  = {PW{1'b0}};
            rd_nxt_s  = {PW{1'b0}};
            cnt_nxt_s = {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_nxt_s = wr_ptr_r + PW'(1);
            end else begin
                wr_nxt_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_nxt_s = rd_ptr_r + PW'(1);
            end else begin
                rd_nxt_s = rd_ptr_r;
            end
            if (push_s && !pop_s) begin
                cnt_nxt_s = cnt_r + CW'(1);
            end else if (!push_s && pop_s) begin
                cnt_nxt_s = cnt_r - CW'(1);
            end else begin
                cnt_nxt_s = cnt_r;
            end
        end
    end

    // Next head payload. When the new head is the slot being written this
    // cycle the array still holds stale data, so take the incoming entry.
    always_comb begin
        head_nxt_s = {EW{1'b0}};
        if (flush || (cnt_nxt_s == {CW{1'b0}})) begin
            head_nxt_s = {EW{1'b0}};
        end else if (push_s && (rd_nxt_s == wr_ptr_r)) begin
            head_nxt_s = new_entry_s;
        end else begin
            head_nxt_s = mem_r[rd_nxt_s];
        end
    end

    // Entry storage; not reset, the head register hides its contents.
    always_ff @(posedge clk) begin
        if (push_s && !flush) begin
            mem_r[wr_ptr_r] <= new_entry_s;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            head_r      <= {EW{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_nxt_s;
            rd_ptr_r    <= rd_nxt_s;
            cnt_r       <= cnt_nxt_s;
            head_r      <= head_nxt_s;
            in_ready_r  <= (cnt_nxt_s < DEPTH_C);
            out_valid_r <= (cnt_nxt_s != {CW{1'b0}});
        end
    end

    // Saturating illegal-instruction counter; a flushed push does not count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_r <= {CNT_W{1'b0}};
        end else if (push_s && !flush && new_entry_s[0] && (ill_cnt_r != CNT_MAX)) begin
            ill_cnt_r <= ill_cnt_r + CNT_W'(1);
        end else begin
            ill_cnt_r <= ill_cnt_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_instr   = head_r[35:4];
    assign out_itype   = head_r[3:1];
    assign out_illegal = head_r[0];
    assign count       = cnt_r;
    assign illegal_cnt = ill_cnt_r;

endmodule

// File: tb/tb_itype_decode_queue.sv
// Testbench for itype_decode_queue: two instances share stimulus, one with the
// base opcode set and a 16-bit counter, one with the extended set and a 2-bit
// counter. A queue-based reference model predicts every output.
module tb_itype_decode_queue;

    localparam int DEPTH = 4;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr  = 32'h0;

    logic        a_in_ready, a_out_valid, a_out_illegal;
    logic [31:0] a_out_instr;
    logic [2:0]  a_out_itype;
    logic [2:0]  a_count;
    logic [15:0] a_ill_cnt;

    logic        b_in_ready, b_out_valid, b_out_illegal;
    logic [31:0] b_out_instr;
    logic [2:0]  b_out_itype;
    logic [2:0]  b_count;
    logic [1:0]  b_ill_cnt;

    int tests = 0;
    int fails = 0;

    logic [31:0] q[$];
    int cnt_a = 0;
    int cnt_b = 0;

    always #5 clk = ~clk;

    itype_decode_queue #(.DEPTH(DEPTH), .EXT_EN(1'b0), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_instr(a_out_instr), .out_itype(a_out_itype), .out_illegal(a_out_illegal),
        .count(a_count), .illegal_cnt(a_ill_cnt)
    );

    itype_decode_queue #(.DEPTH(DEPTH), .EXT_EN(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_instr(in_instr), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_instr(b_out_instr), .out_itype(b_out_itype), .out_illegal(b_out_illegal),
        .count(b_count), .illegal_cnt(b_ill_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference classification: returns {itype, illegal}.
    function automatic logic [3:0] ref_decode(input logic [31:0] instr, input bit ext);
        int op;
        int fn;
        op = int'(instr[31:26]);
        fn = int'(instr[5:0]);
        if (op == 0)                          return (fn != 0) ? 4'b0100 : 4'b0110;
        if (op == 5 || (ext && op == 4))      return 4'b1010;
        if (op == 2 || (ext && op == 3))      return 4'b1100;
        if (op == 43 || op == 35)             return 4'b1000;
        return 4'b0001;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 8);
        case (k)
            0: r[31:26] = 6'd0;
            1: begin r[31:26] = 6'd0; r[5:0] = 6'd0; end
            2: r[31:26] = 6'd5;
            3: r[31:26] = 6'd2;
            4: r[31:26] = 6'd43;
            5: r[31:26] = 6'd35;
            6: r[31:26] = 6'd4;
            7: r[31:26] = 6'd3;
            default: ;
        endcase
        return r;
    endfunction

    task automatic check_all();
        logic [3:0] da;
        logic [3:0] db;
        check("a_count", 32'(a_count), 32'(q.size()));
        check("b_count", 32'(b_count), 32'(q.size()));
        check("a_out_valid", 32'(a_out_valid), 32'(q.size() != 0));
        check("b_out_valid", 32'(b_out_valid), 32'(q.size() != 0));
        check("a_in_ready", 32'(a_in_ready), 32'(q.size() < DEPTH));
        check("b_in_ready", 32'(b_in_ready), 32'(q.size() < DEPTH));
        check("a_illegal_cnt", 32'(a_ill_cnt), 32'(cnt_a));
        check("b_illegal_cnt", 32'(b_ill_cnt), 32'(cnt_b));
        if (q.size() != 0) begin
            da = ref_decode(q[0], 1'b0);
            db = ref_decode(q[0], 1'b1);
            check("a_out_instr", a_out_instr, q[0]);
            check("b_out_instr", b_out_instr, q[0]);
            check("a_out_itype", 32'(a_out_itype), 32'(da[3:1]));
            check("a_out_illegal", 32'(a_out_illegal), 32'(da[0]));
            check("b_out_itype", 32'(b_out_itype), 32'(db[3:1]));
            check("b_out_illegal", 32'(b_out_illegal), 32'(db[0]));
        end
    endtask

    // One clock: check current outputs, drive inputs, advance the model.
    task automatic cycle(input logic v, input logic [31:0] instr, input logic rdy, input logic fl);
        bit push;
        bit pop;
        logic [3:0] da;
        logic [3:0] db;
        check_all();
        in_valid  = v;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
        push = v && (q.size() < DEPTH);
        pop  = rdy && (q.size() != 0);
        da = ref_decode(instr, 1'b0);
        db = ref_decode(instr, 1'b1);
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(instr);
                if (da[0] && cnt_a < 65535) cnt_a++;
                if (db[0] && cnt_b < 3) cnt_b++;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_count"}, 32'(a_count), 32'd0);
        check({tag, "_b_count"}, 32'(b_count), 32'd0);
        check({tag, "_a_out_valid"}, 32'(a_out_valid), 32'd0);
        check({tag, "_a_in_ready"}, 32'(a_in_ready), 32'd1);
        check({tag, "_a_out_instr"}, a_out_instr, 32'd0);
        check({tag, "_a_out_itype"}, 32'(a_out_itype), 32'd0);
        check({tag, "_a_out_illegal"}, 32'(a_out_illegal), 32'd0);
        check({tag, "_a_illegal_cnt"}, 32'(a_ill_cnt), 32'd0);
        check({tag, "_b_illegal_cnt"}, 32'(b_ill_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] seq [5];
        int saved_a;
        int saved_b;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // add instruction: R-type, visible one cycle after push
        cycle(1'b1, 32'h00221820, 1'b0, 1'b0);
        check("add_valid", 32'(a_out_valid), 32'd1);
        check("add_itype", 32'(a_out_itype), 32'(3'b010));
        check("add_illegal", 32'(a_out_illegal), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // beq: illegal without extension, B-type with it
        cycle(1'b1, 32'h10000004, 1'b0, 1'b0);
        check("beq_a_itype", 32'(a_out_itype), 32'(3'b000));
        check("beq_a_illegal", 32'(a_out_illegal), 32'd1);
        check("beq_a_cnt", 32'(a_ill_cnt), 32'd1);
        check("beq_b_itype", 32'(b_out_itype), 32'(3'b101));
        check("beq_b_illegal", 32'(b_out_illegal), 32'd0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Fill past capacity, then drain in order
        for (int i = 0; i < 5; i++) begin
            seq[i] = 32'h00001000 + 32'(i + 1);
            cycle(1'b1, seq[i], 1'b0, 1'b0);
        end
        check("full_in_ready", 32'(a_in_ready), 32'd0);
        check("full_count", 32'(a_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_order", a_out_instr, seq[i]);
            cycle(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("drained_valid", 32'(a_out_valid), 32'd0);

        // Flush at full with push and pop requested
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'hFC000000 + 32'(i), 1'b0, 1'b0);
        saved_a = int'(a_ill_cnt);
        saved_b = int'(b_ill_cnt);
        cycle(1'b1, 32'hFC000010, 1'b1, 1'b1);
        check("flush_full_count", 32'(a_count), 32'd0);
        check("flush_full_valid", 32'(a_out_valid), 32'd0);
        check("flush_full_cnt_a", 32'(a_ill_cnt), 32'(saved_a));

        // Flush with an accepted illegal push: counter must not move
        cycle(1'b1, 32'h00000001, 1'b0, 1'b0);
        saved_a = int'(a_ill_cnt);
        saved_b = int'(b_ill_cnt);
        cycle(1'b1, 32'hFC000000, 1'b0, 1'b1);
        check("flush_push_cnt_a", 32'(a_ill_cnt), 32'(saved_a));
        check("flush_push_cnt_b", 32'(b_ill_cnt), 32'(saved_b));
        check("flush_push_count", 32'(a_count), 32'd0);

        // Saturation of the 2-bit counter
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'hFC000000 + 32'(i), 1'b1, 1'b0);
        check("sat_b_cnt", 32'(b_ill_cnt), 32'd3);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_instr(),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges with three entries queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'hFC000020 + 32'(i), 1'b0, 1'b0);
        check("pre_reset_count", 32'(a_count), 32'd3);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        q.delete();
        cnt_a = 0;
        cnt_b = 0;
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'h8C000000, 1'b0, 1'b0);
        check("post_reset_push_count", 32'(a_count), 32'd1);
        check("post_reset_push_itype", 32'(a_out_itype), 32'(3'b100));
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
